// File: rtl/buyruk_obek_getirici_pkg.sv
// Shared definitions for the instruction-cache refill path: refill FSM state
// encoding, line geometry and the beat-address helper.
package buyruk_onbellek_paket;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTE  = 2'd1,
        YANIT = 2'd2,
        TAMAM = 2'd3
    } durum_t;

    localparam int KELIME_SAYISI          = 4;
    localparam int OBEK_GENISLIGI         = 128;
    localparam int SATIR_OFSET_GENISLIGI  = 4;
    localparam int KELIME_INDIS_GENISLIGI = 2;
    localparam int SATIR_GENISLIGI        = 32 - SATIR_OFSET_GENISLIGI;

    // Word address of beat idx inside the line whose upper bits are satir.
    function automatic logic [31:0] kelime_adresi(
        input logic [SATIR_GENISLIGI-1:0]        satir,
        input logic [KELIME_INDIS_GENISLIGI-1:0] idx
    );
        return {satir, idx, 2'b00};
    endfunction

endpackage

// File: rtl/buyruk_obek_getirici.sv
// Instruction-cache refill engine. Fetches one 128-bit line as four 32-bit
// beats over a valid/ready memory port (one beat outstanding at most),
// assembles the words by address and hands the line to the cache with a
// one-cycle completion pulse and the line-aligned fill address.
// Build option: KRITIK_KELIME_ILK_EN -- when defined, the refill starts at the
// missing word (critical word first) and wraps modulo 4; otherwise it always
// starts at word 0. The assembled line is in natural word order either way.
module buyruk_obek_getirici #(
    parameter int VERI_GENISLIGI = 32,
    parameter int KELIME_SAYISI  = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    istek_i,
    input  logic [31:0]                             istek_adres_i,
    input  logic                                    iptal_i,
    output logic                                    mesgul_o,
    output logic                                    bellek_istek_o,
    output logic [31:0]                             bellek_adres_o,
    input  logic                                    bellek_istek_hazir_i,
    input  logic [VERI_GENISLIGI-1:0]               bellek_veri_i,
    input  logic                                    bellek_veri_gecerli_i,
    output logic [VERI_GENISLIGI*KELIME_SAYISI-1:0] buyruk_obek_o,
    output logic                                    obek_geldi_o,
    output logic [31:0]                             onbellek_yaz_adres_o
);
    import buyruk_onbellek_paket::*;

    localparam int IW = KELIME_INDIS_GENISLIGI;
    localparam logic [IW-1:0] SON_SAYAC = IW'(KELIME_SAYISI - 1);

    durum_t                                  durum_q;
    logic [IW-1:0]                           idx_q;
    logic [IW-1:0]                           sayac_q;
    logic                                    iptal_q;
    logic                                    istek_q;
    logic                                    obek_geldi_q;
    logic [SATIR_GENISLIGI-1:0]              satir_q;
    logic [VERI_GENISLIGI*KELIME_SAYISI-1:0] obek_q;

    logic [IW-1:0]            baslangic_idx;
    logic                     veri_al;
    logic [KELIME_SAYISI-1:0] kelime_yaz_en;
    logic                     unused_adres_bitleri;

`ifdef KRITIK_KELIME_ILK_EN
    // Critical word first: begin with the word that missed.
    assign baslangic_idx        = istek_adres_i[3:2];
    assign unused_adres_bitleri = ^istek_adres_i[1:0];
`else
    // Plain line order: always begin with word 0.
    assign baslangic_idx        = '0;
    assign unused_adres_bitleri = ^istek_adres_i[3:0];
`endif

    // A returned beat is kept only if the refill has not been aborted,
    // either earlier in this YANIT wait or in the very cycle the data arrives.
    assign veri_al = (durum_q == YANIT) && bellek_veri_gecerli_i
                     && !iptal_q && !iptal_i;

    // Refill control FSM with registered control outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q      <= BOSTA;
            idx_q        <= '0;
            sayac_q      <= '0;
            iptal_q      <= 1'b0;
            istek_q      <= 1'b0;
            obek_geldi_q <= 1'b0;
            satir_q      <= '0;
        end else begin
            obek_geldi_q <= 1'b0;
            case (durum_q)
                BOSTA: begin
                    // Abort has priority over a simultaneous new request.
                    if (istek_i && !iptal_i) begin
                        satir_q <= istek_adres_i[31:SATIR_OFSET_GENISLIGI];
                        idx_q   <= baslangic_idx;
                        sayac_q <= '0;
                        iptal_q <= 1'b0;
                        istek_q <= 1'b1;
                        durum_q <= ISTE;
                    end
                end
                ISTE: begin
                    if (iptal_i) begin
                        istek_q <= 1'b0;
                        durum_q <= BOSTA;
                    end else if (bellek_istek_hazir_i) begin
                        istek_q <= 1'b0;
                        durum_q <= YANIT;
                    end
                end
                YANIT: begin
                    if (bellek_veri_gecerli_i) begin
                        if (iptal_q || iptal_i) begin
                            // Outstanding beat has drained; drop it and stop.
                            iptal_q <= 1'b0;
                            durum_q <= BOSTA;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            sayac_q <= sayac_q + 1'b1;
                            if (sayac_q == SON_SAYAC) begin
                                obek_geldi_q <= 1'b1;
                                durum_q      <= TAMAM;
                            end else begin
                                istek_q <= 1'b1;
                                durum_q <= ISTE;
                            end
                        end
                    end else if (iptal_i) begin
                        iptal_q <= 1'b1;
                    end
                end
                TAMAM: begin
                    // The line is already complete, so a late abort does not
                    // suppress the pulse.
                    durum_q <= BOSTA;
                end
                default: begin
                    durum_q <= BOSTA;
                end
            endcase
        end
    end

    // One-hot word select: each beat lands in the slot named by its address.
    always_comb begin
        kelime_yaz_en = '0;
        if (veri_al) begin
            kelime_yaz_en[idx_q] = 1'b1;
        end
    end

    // Line assembly buffer; slots hold until the next refill overwrites them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            obek_q <= '0;
        end else begin
            for (int k = 0; k < KELIME_SAYISI; k++) begin
                if (kelime_yaz_en[k]) begin
                    obek_q[k*VERI_GENISLIGI +: VERI_GENISLIGI] <= bellek_veri_i;
                end
            end
        end
    end

    // Request valid drops combinationally on abort so no handshake can
    // complete in the abort cycle.
    assign bellek_istek_o       = istek_q && !iptal_i;
    assign bellek_adres_o       = kelime_adresi(satir_q, idx_q);
    assign mesgul_o             = (durum_q != BOSTA);
    assign buyruk_obek_o        = obek_q;
    assign obek_geldi_o         = obek_geldi_q;
    assign onbellek_yaz_adres_o = {satir_q, {SATIR_OFSET_GENISLIGI{1'b0}}};

endmodule

// File: tb/tb_buyruk_obek_getirici.sv
// Directed bench for the instruction-cache refill engine: a small memory
// responder with configurable ready/data delays plus manually driven steps
// for abort and reset scenarios.
module tb_buyruk_obek_getirici;

    logic         clk = 1'b0;
    logic         rst;
    logic         istek;
    logic [31:0]  istek_adres;
    logic         iptal;
    logic         mesgul;
    logic         bellek_istek;
    logic [31:0]  bellek_adres;
    logic         bellek_hazir;
    logic [31:0]  bellek_veri;
    logic         bellek_gecerli;
    logic [127:0] obek;
    logic         obek_geldi;
    logic [31:0]  yaz_adres;

    // Manual drive versus memory-responder drive of the memory inputs.
    logic         mem_aktif = 1'b0;
    logic         el_hazir = 1'b0;
    logic         el_gecerli = 1'b0;
    logic [31:0]  el_veri = 32'h0;
    logic         m_hazir = 1'b0;
    logic         m_gecerli = 1'b0;
    logic [31:0]  m_veri = 32'h0;
    int           r_gecikme = 0;
    int           v_gecikme = 0;
    logic [31:0]  veri_maske = 32'h0;
    logic [31:0]  adres_kaydi[$];

    int hata = 0;
    int toplam = 0;

    assign bellek_hazir   = mem_aktif ? m_hazir   : el_hazir;
    assign bellek_gecerli = mem_aktif ? m_gecerli : el_gecerli;
    assign bellek_veri    = mem_aktif ? m_veri    : el_veri;

    always #5 clk = ~clk;

    buyruk_obek_getirici dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .istek_i               (istek),
        .istek_adres_i         (istek_adres),
        .iptal_i               (iptal),
        .mesgul_o              (mesgul),
        .bellek_istek_o        (bellek_istek),
        .bellek_adres_o        (bellek_adres),
        .bellek_istek_hazir_i  (bellek_hazir),
        .bellek_veri_i         (bellek_veri),
        .bellek_veri_gecerli_i (bellek_gecerli),
        .buyruk_obek_o         (obek),
        .obek_geldi_o          (obek_geldi),
        .onbellek_yaz_adres_o  (yaz_adres)
    );

    function automatic logic [31:0] desen(input logic [31:0] a);
        return (32'h11111111 * ({30'd0, a[3:2]} + 32'd1)) ^ veri_maske;
    endfunction

    // Memory responder: decides at posedge+2, commits at the following edge.
    logic        veri_bek = 1'b0;
    logic        kabul_plan = 1'b0;
    logic        veri_plan = 1'b0;
    int          rsay = 0;
    int          vsay = 0;
    logic [31:0] m_adres = 32'h0;

    always begin
        @(posedge clk);
        if (kabul_plan) begin
            veri_bek = 1'b1;
            vsay = 0;
            rsay = 0;
            adres_kaydi.push_back(m_adres);
        end
        if (veri_plan) veri_bek = 1'b0;
        #2;
        m_hazir = 1'b0;
        m_gecerli = 1'b0;
        kabul_plan = 1'b0;
        veri_plan = 1'b0;
        if (mem_aktif) begin
            if (veri_bek) begin
                if (vsay >= v_gecikme) begin
                    m_gecerli = 1'b1;
                    m_veri = desen(m_adres);
                    veri_plan = 1'b1;
                end else begin
                    vsay++;
                end
            end else if (bellek_istek) begin
                if (rsay >= r_gecikme) begin
                    m_hazir = 1'b1;
                    kabul_plan = 1'b1;
                    m_adres = bellek_adres;
                end else begin
                    rsay++;
                end
            end
        end
    end

    task automatic kontrol(input string etiket, input logic [127:0] gozlenen,
                           input logic [127:0] beklenen);
        toplam++;
        assert (gozlenen === beklenen)
        else begin
            hata++;
            $error("FAIL %s: observed=%0h expected=%0h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic saat();
        @(posedge clk);
        #3;
    endtask

    // Runs a refill for up to butce cycles; cycle 1 is the current sample.
    task automatic dolum_bekle(input int butce, output int ilk, output int adet,
                               output int mesgul_dusus, output int adres_oynama,
                               output logic [127:0] obek_anlik,
                               output logic [31:0] yaz_anlik);
        logic        onceki_bekleyen;
        logic [31:0] onceki_adres;
        ilk = -1;
        adet = 0;
        mesgul_dusus = 0;
        adres_oynama = 0;
        obek_anlik = '0;
        yaz_anlik = '0;
        onceki_bekleyen = 1'b0;
        onceki_adres = '0;
        for (int j = 1; j <= butce; j++) begin
            if (obek_geldi) begin
                adet++;
                if (ilk < 0) begin
                    ilk = j;
                    obek_anlik = obek;
                    yaz_anlik = yaz_adres;
                end
            end
            if ((ilk < 0 || ilk == j) && !mesgul) mesgul_dusus++;
            if (onceki_bekleyen && (!bellek_istek || bellek_adres != onceki_adres))
                adres_oynama++;
            onceki_bekleyen = bellek_istek && !bellek_hazir;
            onceki_adres = bellek_adres;
            saat();
        end
    endtask

    task automatic adres_kontrol(input string etiket, input int bas,
                                 input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] bek [4];
        bek[0] = e0; bek[1] = e1; bek[2] = e2; bek[3] = e3;
        kontrol({etiket, "_adet"}, adres_kaydi.size() - bas, 4);
        for (int k = 0; k < 4; k++) begin
            if (bas + k < adres_kaydi.size())
                kontrol($sformatf("%s_adres%0d", etiket, k), adres_kaydi[bas+k], bek[k]);
            else
                kontrol($sformatf("%s_adres%0d_yok", etiket, k), 1'b0, 1'b1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           ilk, adet, md, ao, bas, sayac;
        logic [127:0] ob;
        logic [31:0]  ya;

        rst = 1'b1;
        istek = 1'b0;
        istek_adres = 32'h0;
        iptal = 1'b0;
        #1;
        kontrol("rst_mesgul", mesgul, 0);
        kontrol("rst_istek", bellek_istek, 0);
        kontrol("rst_adres", bellek_adres, 0);
        kontrol("rst_obek", obek, 0);
        kontrol("rst_geldi", obek_geldi, 0);
        kontrol("rst_yaz_adres", yaz_adres, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        saat();
        saat();

        // Basic fill, zero-wait memory.
        mem_aktif = 1'b1;
        r_gecikme = 0;
        v_gecikme = 0;
        veri_maske = 32'h0;
        bas = adres_kaydi.size();
        istek = 1'b1;
        istek_adres = 32'h0000_1234;
        saat();
        istek = 1'b0;
        istek_adres = 32'h0;
        kontrol("temel_istek_N1", bellek_istek, 1);
        dolum_bekle(14, ilk, adet, md, ao, ob, ya);
        kontrol("temel_gecikme", ilk, 9);
        kontrol("temel_darbe", adet, 1);
        kontrol("temel_obek", ob, 128'h44444444_33333333_22222222_11111111);
        kontrol("temel_yaz_adres", ya, 32'h0000_1230);
        kontrol("temel_bosta", mesgul, 0);
`ifdef KRITIK_KELIME_ILK_EN
        adres_kontrol("temel", bas, 32'h1234, 32'h1238, 32'h123C, 32'h1230);
`else
        adres_kontrol("temel", bas, 32'h1230, 32'h1234, 32'h1238, 32'h123C);
`endif

        // Miss on word 2.
        bas = adres_kaydi.size();
        istek = 1'b1;
        istek_adres = 32'h0000_1238;
        saat();
        istek = 1'b0;
        dolum_bekle(14, ilk, adet, md, ao, ob, ya);
        kontrol("kritik_gecikme", ilk, 9);
        kontrol("kritik_obek", ob, 128'h44444444_33333333_22222222_11111111);
        kontrol("kritik_yaz_adres", ya, 32'h0000_1230);
`ifdef KRITIK_KELIME_ILK_EN
        adres_kontrol("kritik", bas, 32'h1238, 32'h123C, 32'h1230, 32'h1234);
`else
        adres_kontrol("kritik", bas, 32'h1230, 32'h1234, 32'h1238, 32'h123C);
`endif

        // Backpressure: ready after 3 low cycles, data 2 cycles late.
        r_gecikme = 3;
        v_gecikme = 2;
        veri_maske = 32'h00FF00FF;
        bas = adres_kaydi.size();
        istek = 1'b1;
        istek_adres = 32'h0000_9AB0;
        saat();
        istek = 1'b0;
        dolum_bekle(34, ilk, adet, md, ao, ob, ya);
        kontrol("basinc_gecikme", ilk, 29);
        kontrol("basinc_darbe", adet, 1);
        kontrol("basinc_mesgul", md, 0);
        kontrol("basinc_adres_sabit", ao, 0);
        kontrol("basinc_obek", ob, 128'h44BB44BB_33CC33CC_22DD22DD_11EE11EE);
        kontrol("basinc_yaz_adres", ya, 32'h0000_9AB0);
        adres_kontrol("basinc", bas, 32'h9AB0, 32'h9AB4, 32'h9AB8, 32'h9ABC);

        // Abort during YANIT of beat 2, after beat 1 landed.
        mem_aktif = 1'b0;
        r_gecikme = 0;
        v_gecikme = 0;
        veri_maske = 32'h0;
        sayac = 0;
        istek = 1'b1;
        istek_adres = 32'h0000_2000;
        saat();
        istek = 1'b0;
        kontrol("iptal_y_adres0", bellek_adres, 32'h2000);
        el_hazir = 1'b1;
        saat();
        el_hazir = 1'b0;
        el_gecerli = 1'b1;
        el_veri = 32'hAAAA0000;
        saat();
        el_gecerli = 1'b0;
        kontrol("iptal_y_adres1", bellek_adres, 32'h2004);
        el_hazir = 1'b1;
        saat();
        el_hazir = 1'b0;
        iptal = 1'b1;
        saat();
        iptal = 1'b0;
        if (obek_geldi) sayac++;
        kontrol("iptal_y_bekliyor", mesgul, 1);
        kontrol("iptal_y_istek_yok", bellek_istek, 0);
        saat();
        if (obek_geldi) sayac++;
        el_gecerli = 1'b1;
        el_veri = 32'hBBBB0000;
        saat();
        el_gecerli = 1'b0;
        if (obek_geldi) sayac++;
        kontrol("iptal_y_bosta", mesgul, 0);
        saat();
        if (obek_geldi) sayac++;
        kontrol("iptal_y_darbe_yok", sayac, 0);
        kontrol("iptal_y_kelime0", obek[31:0], 32'hAAAA0000);
        kontrol("iptal_y_kelime1_atildi", obek[63:32], 32'h22DD22DD);

        // A fresh request after the abort completes normally.
        mem_aktif = 1'b1;
        bas = adres_kaydi.size();
        istek = 1'b1;
        istek_adres = 32'h0000_5678;
        saat();
        istek = 1'b0;
        dolum_bekle(14, ilk, adet, md, ao, ob, ya);
        kontrol("sonra_gecikme", ilk, 9);
        kontrol("sonra_obek", ob, 128'h44444444_33333333_22222222_11111111);
        kontrol("sonra_yaz_adres", ya, 32'h0000_5670);
`ifdef KRITIK_KELIME_ILK_EN
        adres_kontrol("sonra", bas, 32'h5678, 32'h567C, 32'h5670, 32'h5674);
`else
        adres_kontrol("sonra", bas, 32'h5670, 32'h5674, 32'h5678, 32'h567C);
`endif

        // Abort in ISTE with ready held low.
        mem_aktif = 1'b0;
        istek = 1'b1;
        istek_adres = 32'h0000_3000;
        saat();
        istek = 1'b0;
        kontrol("iptal_i_istek_var", bellek_istek, 1);
        saat();
        iptal = 1'b1;
        #1;
        kontrol("iptal_i_ayni_cevrim", bellek_istek, 0);
        saat();
        iptal = 1'b0;
        kontrol("iptal_i_bosta", mesgul, 0);
        kontrol("iptal_i_istek_yok", bellek_istek, 0);

        // Abort together with a request in BOSTA: the request is dropped.
        istek = 1'b1;
        iptal = 1'b1;
        istek_adres = 32'h0000_6000;
        saat();
        istek = 1'b0;
        iptal = 1'b0;
        kontrol("iptal_istek_alinmadi", mesgul, 0);
        kontrol("iptal_istek_yaz_adres", yaz_adres, 32'h0000_3000);

        // Request held high while busy, then async reset mid-beat 2.
        istek = 1'b1;
        istek_adres = 32'h0000_4000;
        saat();
        istek_adres = 32'h0000_7000;
        el_hazir = 1'b1;
        saat();
        el_hazir = 1'b0;
        el_gecerli = 1'b1;
        el_veri = 32'hCAFEF00D;
        saat();
        el_gecerli = 1'b0;
        kontrol("tutulu_istek_yok_sayildi", yaz_adres, 32'h0000_4000);
        kontrol("tutulu_adres1", bellek_adres, 32'h0000_4004);
        el_hazir = 1'b1;
        saat();
        el_hazir = 1'b0;
        istek = 1'b0;
        kontrol("rst_oncesi_mesgul", mesgul, 1);
        #1;
        rst = 1'b1;
        #1;
        kontrol("arst_mesgul", mesgul, 0);
        kontrol("arst_istek", bellek_istek, 0);
        kontrol("arst_adres", bellek_adres, 0);
        kontrol("arst_obek", obek, 0);
        kontrol("arst_geldi", obek_geldi, 0);
        kontrol("arst_yaz_adres", yaz_adres, 0);
        #1;
        rst = 1'b0;
        el_gecerli = 1'b1;
        el_veri = 32'hDEAD0000;
        saat();
        el_gecerli = 1'b0;
        kontrol("basibos_mesgul", mesgul, 0);
        kontrol("basibos_obek", obek, 0);
        kontrol("basibos_geldi", obek_geldi, 0);
        saat();

        $display("Result: errors=%0d of %0d checks", hata, toplam);
        $finish;
    end

endmodule

// File: doc/buyruk_obek_getirici.md
# buyruk_obek_getirici

Instruction-cache refill engine between the instruction cache and the main-memory port. On a miss request it reads a 128-bit line as four 32-bit beats over a valid/ready memory interface and assembles them into a block. It then presents the block with a one-cycle completion pulse and the line-aligned write address, which the cache uses as its fill block, fill-done and fill-address inputs.

## Interface
Parameters
- `VERI_GENISLIGI`, 32: memory beat width; fixed at 32.
- `KELIME_SAYISI`, 4: beats per line; fixed at 4, giving a 128-bit line.

Ports
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `istek_i`  in  1  refill request; sampled only in BOSTA.
- `istek_adres_i`  in  32  miss address; any byte offset.
- `iptal_i`  in  1  abort the current refill (flush or redirect).
- `mesgul_o`  out  1  high whenever state is not BOSTA.
- `bellek_istek_o`  out  1  beat read request valid.
- `bellek_adres_o`  out  32  beat word address.
- `bellek_istek_hazir_i`  in  1  memory accepts the request this cycle.
- `bellek_veri_i`  in  32  beat read data.
- `bellek_veri_gecerli_i`  in  1  beat data valid.
- `buyruk_obek_o`  out  128  assembled line; word k is at [32k+31:32k].
- `obek_geldi_o`  out  1  one-cycle pulse: the line is complete.
- `onbellek_yaz_adres_o`  out  32  line base, {adres[31:4], 4'b0}.

## Operation
- States:
  - BOSTA: if `istek_i`, latch the line base and start index, go to ISTE.
  - ISTE: drive `bellek_istek_o`=1 and `bellek_adres_o`=base+4*idx. On `bellek_istek_hazir_i`, go to YANIT.
  - YANIT: wait for `bellek_veri_gecerli_i`. On valid data, write word slot idx, idx=(idx+1) mod 4, count++. After the 4th beat go to TAMAM, otherwise go to ISTE.
  - TAMAM: `obek_geldi_o`=1 for this one cycle, then go to BOSTA.
- One outstanding beat at most. `bellek_veri_gecerli_i` outside YANIT is ignored.
- `istek_i` while busy is ignored; no queueing.
- Line assembly:
  - Slots are written by address, so `buyruk_obek_o` is in natural word order regardless of fetch order.
  - The buffer holds its value until overwritten by the next refill.
- Abort with `iptal_i`:
  - In ISTE: drop `bellek_istek_o` in the same cycle (combinational) and go to BOSTA.
  - In YANIT: set the abort flag, wait for the outstanding beat, discard it, go to BOSTA.
  - In TAMAM: the pulse still fires.
  - `obek_geldi_o` never fires for an aborted line.
- `iptal_i` together with `istek_i` in BOSTA: `iptal_i` wins and the request is not taken.
- Reset mid-refill: immediate return to BOSTA. An in-flight memory response after reset is ignored because the block is in BOSTA.

## Timing
- Reset values:
  - state BOSTA
  - `mesgul_o`=0, `bellek_istek_o`=0, `bellek_adres_o`=0
  - `buyruk_obek_o`=0, `obek_geldi_o`=0, `onbellek_yaz_adres_o`=0
  - idx and count 0, abort flag 0
- `istek_i` high at edge N gives `bellek_istek_o`=1 from cycle N+1.
- Minimum latency, with ready immediate and data one cycle later: `obek_geldi_o` in cycle N+9.
- `bellek_adres_o` and `bellek_istek_o` hold stable until accepted, except on abort.
- `onbellek_yaz_adres_o` is registered at acceptance and held until the next acceptance. It is valid together with `obek_geldi_o`.
- `buyruk_obek_o` is complete and stable in the `obek_geldi_o` cycle and stays stable until the next refill starts.

## Configuration
- `KRITIK_KELIME_ILK_EN` defined: start idx = `istek_adres_i`[3:2]. Beats run critical word first and wrap modulo 4; for example, start 2 fetches 2,3,0,1.
- Not defined: start idx = 0, fetch order 0,1,2,3.
- The output format is identical in both builds.

## Structure
- Shared package `buyruk_onbellek_paket`:
  - state encodings BOSTA, ISTE, YANIT, TAMAM (2 bits)
  - `KELIME_SAYISI`, `OBEK_GENISLIGI`=128
  - line offset width 4
- No sub-module needed. The 128-bit assembly buffer with per-word write enable is inline.

## Test plan
- Basic fill: `istek_adres_i`=0x0000_1234, memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Addresses must be 0x1230, 0x1234, 0x1238, 0x123C.
  - Expect `obek_geldi_o` at N+9, `buyruk_obek_o`=0x44444444_33333333_22222222_11111111, `onbellek_yaz_adres_o`=0x0000_1230.
- Critical word first with the macro: address 0x0000_1238.
  - Beat order must be 0x1238, 0x123C, 0x1230, 0x1234.
  - The line must be in natural order, same as the basic-fill case.
- Backpressure: ready low for 3 cycles per beat and data delay of 2 cycles.
  - `bellek_adres_o` must stay stable until accepted.
  - Single `obek_geldi_o` pulse.
  - `mesgul_o` high throughout.
- Abort during YANIT after beat 1: assert `iptal_i`, then return data.
  - No `obek_geldi_o`; back in BOSTA one cycle after the data.
  - A new `istek_i` then completes normally.
- Abort in ISTE with ready held low: `bellek_istek_o` must drop in the same cycle, then BOSTA.
- Asynchronous `rst_i` mid-beat 2:
  - All outputs go to zero without a clock edge.
  - A stray `bellek_veri_gecerli_i` afterwards has no effect.
  - `istek_i` held high during the refill is ignored until BOSTA.
